// File: rtl/alu_pkg.sv
// Shared types and default sizing for the sequential wide adder.
// The state encoding and slice geometry defaults live here.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_SLICES = 4;

endpackage

// File: rtl/adder_full.sv
// Combinational WIDTH-bit ripple slice adder with carry in and carry out.
module ADDER_FULL #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_IN,
  output logic [WIDTH-1:0] SUM,
  output logic             C_OUT
);

  logic [WIDTH:0] total_s;

  assign total_s = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, C_IN};
  assign SUM     = total_s[WIDTH-1:0];
  assign C_OUT   = total_s[WIDTH];

endmodule

// File: rtl/wide_add_sequencer.sv
// Adds two N-bit operands one WIDTH-bit slice per clock through a single
// shared slice adder, then pulses DONE and holds SUM/C_OUT/OVF.
module wide_add_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SLICES = DEF_SLICES
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      START,
  input  logic [WIDTH*SLICES-1:0]   A,
  input  logic [WIDTH*SLICES-1:0]   B,
  input  logic                      C_IN,
  output logic                      BUSY,
  output logic                      DONE,
  output logic [WIDTH*SLICES-1:0]   SUM,
  output logic                      C_OUT,
  output logic                      OVF
);

  localparam int N  = WIDTH * SLICES;
  localparam int IW = $clog2(SLICES) + 1;

  state_t           state_r;
  state_t           next_state_s;
  logic [N-1:0]     op_a_r;
  logic [N-1:0]     op_b_r;
  logic [N-1:0]     sum_r;
  logic [IW-1:0]    idx_r;
  logic             carry_r;
  logic             c_out_r;
  logic             ovf_r;
  logic             busy_r;
  logic             done_r;
  logic             accept_s;
  logic             last_s;
  logic [WIDTH-1:0] slice_a_s;
  logic [WIDTH-1:0] slice_b_s;
  logic [WIDTH-1:0] slice_sum_s;
  logic             slice_carry_s;

  assign accept_s  = START && (state_r != RUN);
  assign last_s    = (idx_r == IW'(SLICES - 1));
  assign slice_a_s = op_a_r[int'(idx_r) * WIDTH +: WIDTH];
  assign slice_b_s = op_b_r[int'(idx_r) * WIDTH +: WIDTH];

  ADDER_FULL #(.WIDTH(WIDTH)) u_slice_adder (
    .A     (slice_a_s),
    .B     (slice_b_s),
    .C_IN  (carry_r),
    .SUM   (slice_sum_s),
    .C_OUT (slice_carry_s)
  );

  // Next-state decode: START is honoured only outside RUN.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    if (START) next_state_s = RUN;    else next_state_s = IDLE;
      RUN:     if (last_s) next_state_s = FINISH; else next_state_s = RUN;
      FINISH:  if (START) next_state_s = RUN;    else next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State plus BUSY/DONE registered from the next state so they align with it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s == RUN);
      done_r  <= (next_state_s == FINISH);
    end
  end

  // Operand capture and slice-by-slice accumulation; overflow uses the top slice.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op_a_r  <= '0;
      op_b_r  <= '0;
      sum_r   <= '0;
      idx_r   <= '0;
      carry_r <= 1'b0;
      c_out_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (accept_s) begin
      op_a_r  <= A;
      op_b_r  <= B;
      sum_r   <= '0;
      idx_r   <= '0;
      carry_r <= C_IN;
      c_out_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (state_r == RUN) begin
      sum_r[int'(idx_r) * WIDTH +: WIDTH] <= slice_sum_s;
      carry_r <= slice_carry_s;
      idx_r   <= idx_r + IW'(1);
      if (last_s) begin
        c_out_r <= slice_carry_s;
        ovf_r   <= (op_a_r[N-1] == op_b_r[N-1]) && (slice_sum_s[WIDTH-1] != op_a_r[N-1]);
      end
    end
  end

  assign BUSY  = busy_r;
  assign DONE  = done_r;
  assign SUM   = sum_r;
  assign C_OUT = c_out_r;
  assign OVF   = ovf_r;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Randomised and directed checks of the sequential wide adder against an
// arithmetic reference, with a 4x4 instance and a single-slice instance.
module tb_wide_add_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = 16'h0;
  logic [15:0] b = 16'h0;
  logic        c_in = 1'b0;
  logic        busy, done, c_out, ovf;
  logic [15:0] sum;

  logic        s1_start = 1'b0;
  logic [3:0]  s1_a = 4'h0;
  logic [3:0]  s1_b = 4'h0;
  logic        s1_c_in = 1'b0;
  logic        s1_busy, s1_done, s1_c_out, s1_ovf;
  logic [3:0]  s1_sum;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  wide_add_sequencer #(.WIDTH(4), .SLICES(4)) dut (
    .CLK(clk), .RST(rst), .START(start), .A(a), .B(b), .C_IN(c_in),
    .BUSY(busy), .DONE(done), .SUM(sum), .C_OUT(c_out), .OVF(ovf)
  );

  wide_add_sequencer #(.WIDTH(4), .SLICES(1)) dut1 (
    .CLK(clk), .RST(rst), .START(s1_start), .A(s1_a), .B(s1_b), .C_IN(s1_c_in),
    .BUSY(s1_busy), .DONE(s1_done), .SUM(s1_sum), .C_OUT(s1_c_out), .OVF(s1_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result packed as {ovf, c_out, sum[15:0]}.
  function automatic logic [17:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic ci);
    int unsigned t;
    logic [15:0] s;
    logic co, ov;
    t  = int'(x) + int'(y) + int'(ci);
    s  = t[15:0];
    co = (t > 32'd65535);
    ov = (x[15] == y[15]) && (s[15] != x[15]);
    return {ov, co, s};
  endfunction

  // Called at a negedge one cycle after the accepting edge.  Walks the RUN
  // cycles (optionally disturbing inputs) and stops at the DONE cycle.
  task automatic run_and_check(input logic [15:0] x, input logic [15:0] y, input logic ci,
                               input bit disturb, input string tag);
    logic [17:0] r;
    r = ref16(x, y, ci);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_busy"}, busy, 1'b1);
      check({tag, "_nodone"}, done, 1'b0);
      if (disturb && i == 1) begin
        start = 1'b1;
        a = 16'($urandom);
        b = 16'($urandom);
        c_in = 1'($urandom);
      end else begin
        start = 1'b0;
        if (disturb) begin
          a = 16'($urandom);
          b = 16'($urandom);
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_busy_off"}, busy, 1'b0);
    check({tag, "_sum"}, sum, r[15:0]);
    check({tag, "_cout"}, c_out, r[16]);
    check({tag, "_ovf"}, ovf, r[17]);
  endtask

  task automatic launch(input logic [15:0] x, input logic [15:0] y, input logic ci);
    a = x; b = y; c_in = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic single_op(input logic [15:0] x, input logic [15:0] y, input logic ci,
                           input bit disturb, input string tag);
    logic [17:0] r;
    r = ref16(x, y, ci);
    launch(x, y, ci);
    run_and_check(x, y, ci, disturb, tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_idle"}, busy, 1'b0);
    check({tag, "_hold"}, {ovf, c_out, sum}, r);
  endtask

  task automatic s1_op(input logic [3:0] x, input logic [3:0] y, input logic ci, input string tag);
    logic [4:0] t;
    logic ov;
    t  = {1'b0, x} + {1'b0, y} + {4'b0, ci};
    ov = (x[3] == y[3]) && (t[3] != x[3]);
    s1_a = x; s1_b = y; s1_c_in = ci; s1_start = 1'b1;
    @(negedge clk);
    s1_start = 1'b0;
    check({tag, "_busy"}, s1_busy, 1'b1);
    check({tag, "_nodone"}, s1_done, 1'b0);
    @(negedge clk);
    check({tag, "_done"}, s1_done, 1'b1);
    check({tag, "_res"}, {s1_ovf, s1_c_out, s1_sum}, {ov, t[4], t[3:0]});
    @(negedge clk);
    check({tag, "_done_pulse"}, s1_done, 1'b0);
  endtask

  initial begin
    logic [15:0] x, y;
    #2;
    check("rst_state", {busy, done, c_out, ovf, sum}, 20'h0);
    check("rst_state_s1", {s1_busy, s1_done, s1_c_out, s1_ovf, s1_sum}, 8'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    single_op(16'h0005, 16'h0001, 1'b0, 1'b0, "basic");
    single_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "wrap");
    single_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, "ovf");
    single_op(16'h0002, 16'h0000, 1'b1, 1'b1, "ignore_start");

    // Back-to-back: START held through FINISH launches the second add at once.
    launch(16'h1234, 16'h4321, 1'b0);
    run_and_check(16'h1234, 16'h4321, 1'b0, 1'b0, "b2b_first");
    a = 16'h00E0; b = 16'h0020; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_and_check(16'h00E0, 16'h0020, 1'b0, 1'b0, "b2b_second");
    @(negedge clk);
    check("b2b_end", done, 1'b0);

    // Reset in the third RUN cycle aborts without DONE.
    launch(16'h1111, 16'h2222, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1 check("rst_abort", {busy, done, c_out, ovf, sum}, 20'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_no_done", done, 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    single_op(16'h0006, 16'h0004, 1'b1, 1'b0, "after_rst");

    for (int n = 0; n < 24; n++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      if (n % 6 == 0) y = 16'h8000 - x;
      single_op(x, y, 1'($urandom), bit'($urandom_range(0, 1)), "rand");
    end

    s1_op(4'hE, 4'h2, 1'b0, "s1_wrap");
    for (int n = 0; n < 8; n++)
      s1_op(4'($urandom), 4'($urandom), 1'($urandom), "s1_rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
